// File: rtl/scr1_pipe_fprf_wrctl.sv
// FPRF write-port controller.
// Arbitrates the single FPRF write port among LSU, FPU and EXU move results,
// registers the winning write for the FPRF and keeps a per-register busy
// scoreboard used by the EXU for RAW stalls and WAW issue refusal.
// Optional build macro: SCR1_FPRF_WRCTL_AGING_EN adds per-producer age
// counters so a starved requester is promoted to top priority.
module scr1_pipe_fprf_wrctl #(
    localparam int unsigned SCR1_MPRF_AWIDTH = 5,
    localparam int unsigned SCR1_XLEN        = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,

    // EXU issue / scoreboard query
    input  logic                        exu2wrctl_issue_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] exu2wrctl_issue_frd_i,
    output logic                        wrctl2exu_issue_rdy_o,
    input  logic [SCR1_MPRF_AWIDTH-1:0] exu2wrctl_frs1_addr_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] exu2wrctl_frs2_addr_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] exu2wrctl_frs3_addr_i,
    output logic                        wrctl2exu_frs1_busy_o,
    output logic                        wrctl2exu_frs2_busy_o,
    output logic                        wrctl2exu_frs3_busy_o,

    // LSU load results
    input  logic                        lsu2wrctl_req_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] lsu2wrctl_frd_i,
    input  logic [SCR1_XLEN-1:0]        lsu2wrctl_data_i,
    output logic                        wrctl2lsu_ack_o,

    // FPU arithmetic results
    input  logic                        fpu2wrctl_req_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] fpu2wrctl_frd_i,
    input  logic [SCR1_XLEN-1:0]        fpu2wrctl_data_i,
    output logic                        wrctl2fpu_ack_o,

    // EXU integer-to-FP moves
    input  logic                        mov2wrctl_req_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] mov2wrctl_frd_i,
    input  logic [SCR1_XLEN-1:0]        mov2wrctl_data_i,
    output logic                        wrctl2mov_ack_o,

    // FPRF write interface
    output logic                        wrctl2fprf_w_req_o,
    output logic [SCR1_MPRF_AWIDTH-1:0] wrctl2fprf_frd_addr_o,
    output logic [SCR1_XLEN-1:0]        wrctl2fprf_frd_data_o
);

    localparam int unsigned NumRegs = 2 ** SCR1_MPRF_AWIDTH;

    // Producer index order inside packed vectors: 0 = lsu, 1 = fpu, 2 = mov
    logic [2:0]                  req;
    logic [2:0]                  grant;

    logic [NumRegs-1:1]          busy_q;
    logic [NumRegs-1:1]          busy_d;
    logic [NumRegs-1:0]          busy_full;
    logic [NumRegs-1:0]          busy_next_full;

    logic                        w_req_q;
    logic [SCR1_MPRF_AWIDTH-1:0] w_addr_q;
    logic [SCR1_XLEN-1:0]        w_data_q;

    logic [SCR1_MPRF_AWIDTH-1:0] win_frd;
    logic [SCR1_XLEN-1:0]        win_data;
    logic                        issue_set;

    assign req = {mov2wrctl_req_i, fpu2wrctl_req_i, lsu2wrctl_req_i};

    // f0 is hard-wired not busy; keeping it as a constant bit lets every
    // lookup index the full vector directly with a raw register address.
    assign busy_full = {busy_q, 1'b0};

    // Issue handshake: refuse issue to a destination that is still pending
    always_comb begin
        wrctl2exu_issue_rdy_o = !exu2wrctl_issue_i || !busy_full[exu2wrctl_issue_frd_i];
        issue_set = exu2wrctl_issue_i && wrctl2exu_issue_rdy_o
                    && (exu2wrctl_issue_frd_i != '0);
    end

    // Source busy check; the write stage still counts as pending because the
    // FPRF only commits at the end of that cycle.
    always_comb begin
        wrctl2exu_frs1_busy_o = busy_full[exu2wrctl_frs1_addr_i]
                                || (w_req_q && (w_addr_q == exu2wrctl_frs1_addr_i)
                                    && (exu2wrctl_frs1_addr_i != '0));
        wrctl2exu_frs2_busy_o = busy_full[exu2wrctl_frs2_addr_i]
                                || (w_req_q && (w_addr_q == exu2wrctl_frs2_addr_i)
                                    && (exu2wrctl_frs2_addr_i != '0));
        wrctl2exu_frs3_busy_o = busy_full[exu2wrctl_frs3_addr_i]
                                || (w_req_q && (w_addr_q == exu2wrctl_frs3_addr_i)
                                    && (exu2wrctl_frs3_addr_i != '0));
    end

    // Scoreboard next state: clear on committed write, then set on issue so
    // that a same-edge set wins over a clear.
    always_comb begin
        busy_next_full = busy_full;
        if (w_req_q) begin
            busy_next_full[w_addr_q] = 1'b0;
        end
        if (issue_set) begin
            busy_next_full[exu2wrctl_issue_frd_i] = 1'b1;
        end
        busy_d = busy_next_full[NumRegs-1:1];
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef SCR1_FPRF_WRCTL_AGING_EN
    logic [2:0][1:0] age_q;
    logic [2:0][1:0] age_d;
    logic [2:0]      aged;

    // Producers that have waited three cycles are promoted ahead of the rest
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            aged[i] = req[i] && (age_q[i] == 2'd3);
        end
        grant = 3'b000;
        if (aged[0]) begin
            grant = 3'b001;
        end else if (aged[1]) begin
            grant = 3'b010;
        end else if (aged[2]) begin
            grant = 3'b100;
        end else if (req[0]) begin
            grant = 3'b001;
        end else if (req[1]) begin
            grant = 3'b010;
        end else if (req[2]) begin
            grant = 3'b100;
        end
    end

    // Age counters count unserved request cycles and saturate at three
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (!req[i] || grant[i]) begin
                age_d[i] = 2'd0;
            end else if (age_q[i] == 2'd3) begin
                age_d[i] = 2'd3;
            end else begin
                age_d[i] = age_q[i] + 2'd1;
            end
        end
    end

    // Age counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    // Pure fixed priority: lsu > fpu > mov
    always_comb begin
        grant = 3'b000;
        if (req[0]) begin
            grant = 3'b001;
        end else if (req[1]) begin
            grant = 3'b010;
        end else if (req[2]) begin
            grant = 3'b100;
        end
    end
`endif

    assign wrctl2lsu_ack_o = grant[0];
    assign wrctl2fpu_ack_o = grant[1];
    assign wrctl2mov_ack_o = grant[2];

    // Select the winning producer's destination and data
    always_comb begin
        win_frd  = '0;
        win_data = '0;
        unique case (grant)
            3'b001: begin
                win_frd  = lsu2wrctl_frd_i;
                win_data = lsu2wrctl_data_i;
            end
            3'b010: begin
                win_frd  = fpu2wrctl_frd_i;
                win_data = fpu2wrctl_data_i;
            end
            3'b100: begin
                win_frd  = mov2wrctl_frd_i;
                win_data = mov2wrctl_data_i;
            end
            default: begin
                win_frd  = '0;
                win_data = '0;
            end
        endcase
    end

    // Write stage: one-cycle pulse to the FPRF per granted result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_req_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            w_req_q <= |grant;
            if (|grant) begin
                w_addr_q <= win_frd;
                w_data_q <= win_data;
            end
        end
    end

    assign wrctl2fprf_w_req_o    = w_req_q;
    assign wrctl2fprf_frd_addr_o = w_addr_q;
    assign wrctl2fprf_frd_data_o = w_data_q;

    // A granted result must target a pending destination (f0 excepted)
    logic win_unexpected;
    assign win_unexpected = (|grant) && (win_frd != '0) && !busy_full[win_frd];

    a_write_to_idle_dest : assert property (
        @(posedge clk) disable iff (!rst_n) !win_unexpected
    ) else $error("wrctl: result written to non-pending f%0d", win_frd);

endmodule
